clk_en_divider_bank: RTL and testbench
======================================

// Module: clk_en_divider_bank
// PURPOSE
//  Parametrised bank of NCH clock-enable dividers plus one periodic interrupt generator, all on the
//  single system clk. Replaces the fixed 3MHz/3KHz/12KHz/48KHz counters and the NMI counter in the
//  game top level. Adds runtime-programmable divisors, per-channel phase and cascaded channels.
//  Consumers (CPU, AVG, sound, POKEY) use en_o as one-cycle clock enables.
// PARAMETERS
//  NCH        4                     number of divider channels (1..8)
//  CW         16                    counter/divisor width
//  DIV_INIT   {16'd511,...}         per-channel reset divisor; period = DIV+1 ticks
//  PHASE_INIT {16'd0,...}           per-channel counter reset value (must be <= DIV_INIT[i])
//  CASCADE    4'b0000               bit i=1: ch i ticks on en_o[i-1] (bit 0 ignored)
//  IRQ_SRC    1                     channel whose en_o clocks the IRQ counter
//  IRQ_PERIOD 14                    IRQ counter modulus (2..16)
//  IRQ_PHASE  12                    IRQ counter value at which irq_o asserts
// PORTS
//  clk       in   1            system clock
//  rst       in   1            synchronous, active-high reset
//  run       in   1            global tick; 0 freezes all channels and the IRQ counter
//  cfg_we    in   1            divisor write strobe
//  cfg_ch    in   $clog2(NCH)  channel index for write
//  cfg_div   in   CW           new divisor (period-1)
//  cfg_ack   out  1            1-cycle pulse: staged divisor applied
//  en_o      out  NCH          1-cycle clock-enable pulses
//  level_o   out  NCH          ~50% duty square wave per channel
//  irq_o     out  1            periodic interrupt level
// BEHAVIOUR
//  Reset: cnt[i]=PHASE_INIT[i], div[i]=DIV_INIT[i], pending=0, irq_cnt=0.
//  During reset: en_o=0, irq_o=0, cfg_ack=0.
//  tick[i] = CASCADE[i] ? en_o[i-1] : run. Cascade is combinational, same cycle, no added latency.
//  en_o[i] = !rst && tick[i] && cnt[i]==div[i]. Combinational from registered cnt/div.
//  On tick[i]: cnt <= (cnt==div) ? 0 : cnt+1. No tick: cnt holds.
//  level_o[i] = cnt[i] >= ((div[i]+1)>>1), registered-derived. div=0: en_o on every tick, level_o=1.
//  Divisor update is glitch-free. A cfg_we with cfg_ch<NCH stores cfg_div in shadow[ch] and sets
//  pending[ch] next cycle. At the first en_o[ch] with pending=1: div<=shadow, pending<=0, cnt<=0,
//  and cfg_ack pulses the following cycle.
//  Write coinciding with en_o of the same channel: applied at the next terminal count, not the current one.
//  Re-write while pending: shadow overwritten; one ack only.
//  cfg_ch>=NCH: ignored, no ack.
//  Writes to different channels may be pending simultaneously. cfg_ack is a single port, so
//  simultaneous applies produce one ack pulse.
//  Divisor < current cnt: counter continues to CW wrap. Forbidden by use; not corrected in RTL.
//  IRQ: on en_o[IRQ_SRC], irq_o <= (irq_cnt==IRQ_PHASE) and irq_cnt <= (irq_cnt==IRQ_PERIOD-1) ? 0 : irq_cnt+1.
//  irq_o is therefore high for exactly one source period out of IRQ_PERIOD.
//  run=0 mid-period: all state holds; resumes exactly where stopped.
//  rst mid-operation: all state returns to reset values on the next edge; pending writes are lost.
// STRUCTURE
//  Package clk_en_pkg: CW default, divisor_t typedef, default DIV_INIT/PHASE_INIT arrays.
//  Sub-module clk_en_channel (one divider, shadow register, pending flag); instantiated NCH times
//  by generate. The IRQ counter and ack OR-reduce sit in the top of this block.
// TESTING
//  1. DIV_INIT=7, PHASE_INIT=0, run=1 after reset -> first en_o[0] on cycle 8 after rst release,
//     then every 8 cycles; level_o low 4, high 4.
//  2. CASCADE=4'b0010, div0=3, div1=1 -> en_o[1] every 8 clk, coincident with every 2nd en_o[0].
//  3. cfg_we ch0 div=15 mid-period -> old period completes, cfg_ack 1 cycle after that en_o,
//     then period 16. Repeat with the write on the en_o cycle -> applied one period later.
//  4. Two writes to ch2 (9 then 5) before terminal -> single ack, period 6.
//     Write with cfg_ch=NCH -> no ack, no change.
//  5. IRQ_SRC period 10, IRQ_PERIOD=14, IRQ_PHASE=12 -> irq_o high 10 cycles every 140 cycles,
//     first rise on 13th source pulse.
//  6. run=0 for 50 cycles mid-count, then rst asserted mid-run -> counts frozen, en_o=0;
//     after rst all counters at PHASE_INIT, irq_o=0, pending cleared.

Source files
------------

// File: rtl/clk_en_pkg.sv
// Shared widths, divisor type and reset tables for the clock-enable divider bank.
package clk_en_pkg;

    localparam int CW_DEF  = 16;
    localparam int NCH_DEF = 4;

    typedef logic [CW_DEF-1:0] divisor_t;

    // Reset divisor 511 gives a 512-tick period on every channel.
    localparam divisor_t [NCH_DEF-1:0] DIV_INIT_DEF   = {NCH_DEF{divisor_t'(511)}};
    localparam divisor_t [NCH_DEF-1:0] PHASE_INIT_DEF = '0;

endpackage

// File: rtl/clk_en_channel.sv
// One divider channel: free-running modulo counter, shadow divisor and pending flag.
module clk_en_channel
    import clk_en_pkg::*;
#(
    parameter int            CW         = CW_DEF,
    parameter logic [CW-1:0] DIV_INIT   = CW'(511),
    parameter logic [CW-1:0] PHASE_INIT = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    output logic          en,
    output logic          level,
    output logic          apply
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] div;
    logic [CW-1:0] shadow;
    logic          pending;

    // Threshold for the square wave; one extra bit so div = all-ones cannot overflow.
    function automatic logic [CW:0] half_period(input logic [CW-1:0] d);
        return ({1'b0, d} + 1'b1) >> 1;
    endfunction

    assign en    = !rst && tick && (cnt == div);
    assign apply = en && pending;
    assign level = {1'b0, cnt} >= half_period(div);

    always_ff @(posedge clk) begin
        if (wr) begin
            shadow <= wr_div;
        end
    end

    // A staged divisor only lands on a terminal count, so no short or long period is ever emitted.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= PHASE_INIT;
            div     <= DIV_INIT;
            pending <= 1'b0;
        end else begin
            if (apply) begin
                div <= shadow;
            end
            if (wr) begin
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            if (tick) begin
                cnt <= (cnt == div) ? '0 : cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_en_divider_bank.sv
// Bank of programmable clock-enable dividers with optional cascading and a periodic IRQ.
module clk_en_divider_bank
    import clk_en_pkg::*;
#(
    parameter int                      NCH        = NCH_DEF,
    parameter int                      CW         = CW_DEF,
    parameter logic [NCH-1:0][CW-1:0]  DIV_INIT   = DIV_INIT_DEF,
    parameter logic [NCH-1:0][CW-1:0]  PHASE_INIT = PHASE_INIT_DEF,
    parameter logic [NCH-1:0]          CASCADE    = '0,
    parameter int                      IRQ_SRC    = 1,
    parameter int                      IRQ_PERIOD = 14,
    parameter int                      IRQ_PHASE  = 12,
    localparam int                     CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    output logic           cfg_ack,
    output logic [NCH-1:0] en_o,
    output logic [NCH-1:0] level_o,
    output logic           irq_o
);

    localparam int            IW       = $clog2(IRQ_PERIOD);
    localparam logic [IW-1:0] IRQ_LAST = IW'(IRQ_PERIOD - 1);
    localparam logic [IW-1:0] IRQ_HIT  = IW'(IRQ_PHASE);

    logic [NCH-1:0] apply;
    logic [IW-1:0]  irq_cnt;

    // Per-channel locals keep the cascade chain free of a self-referencing vector.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        localparam logic [CHW-1:0] CH_IDX = CHW'(i);
        logic tick_ch;
        logic en_ch;
        logic level_ch;
        logic apply_ch;

        if (i > 0 && CASCADE[i]) begin : g_casc
            assign tick_ch = g_ch[i-1].en_ch;
        end else begin : g_run
            assign tick_ch = run;
        end

        clk_en_channel #(
            .CW         (CW),
            .DIV_INIT   (DIV_INIT[i]),
            .PHASE_INIT (PHASE_INIT[i])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .tick   (tick_ch),
            .wr     (cfg_we && (cfg_ch == CH_IDX)),
            .wr_div (cfg_div),
            .en     (en_ch),
            .level  (level_ch),
            .apply  (apply_ch)
        );

        assign en_o[i]    = en_ch;
        assign level_o[i] = level_ch;
        assign apply[i]   = apply_ch;
    end

    // irq_o follows the counter one source pulse late, giving a full source period high.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_cnt <= '0;
            irq_o   <= 1'b0;
            cfg_ack <= 1'b0;
        end else begin
            cfg_ack <= |apply;
            if (en_o[IRQ_SRC]) begin
                irq_o   <= (irq_cnt == IRQ_HIT);
                irq_cnt <= (irq_cnt == IRQ_LAST) ? '0 : irq_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_en_divider_bank.sv
// Scoreboard bench: stimulus queues expected event cycles, a negedge monitor pops and compares.
module tb_clk_en_divider_bank;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int NS  = 6;   // en0, en1, en2, ack, irq rise, irq fall
    localparam int C1  = 257; // second reset release, offset from first release
    localparam int END = C1 + 290;

    localparam int EN0_OFS [28] = '{7, 15, 23, 31, 39, 47, 51, 55, 59, 63, 67, 71, 75, 79,
                                    83, 99, 115, 131, 147, 153, 159, 165, 171, 177, 183, 189,
                                    195, 251};
    localparam int EN1_OFS [14] = '{15, 31, 47, 55, 63, 71, 79, 99, 131, 153, 165, 177, 189, 251};
    localparam int EN2_TAIL [5] = '{179, 185, 191, 197, 253};
    localparam int ACK_OFS  [4] = '{48, 84, 148, 180};

    logic           clk = 1'b0;
    logic           rst;
    logic           run;
    logic           cfg_we;
    logic [1:0]     cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_ack;
    logic [NCH-1:0] en_o;
    logic [NCH-1:0] level_o;
    logic           irq_o;

    int    cyc = 0;
    int    c0 = 0;
    int    n_checks = 0;
    int    n_err = 0;
    bit    watch = 1'b0;
    logic  irq_prev = 1'b0;
    int    exp_q [NS][$];
    string sname [NS] = '{"en0", "en1", "en2", "ack", "irq_rise", "irq_fall"};

    clk_en_divider_bank #(
        .NCH        (NCH),
        .CW         (CW),
        .DIV_INIT   ({16'd9, 16'd1, 16'd7}),
        .PHASE_INIT ('0),
        .CASCADE    (3'b010),
        .IRQ_SRC    (2),
        .IRQ_PERIOD (14),
        .IRQ_PHASE  (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_ack (cfg_ack),
        .en_o    (en_o),
        .level_o (level_o),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        logic [NS-1:0] ev;
        int            e;
        ev = {!irq_o && irq_prev, irq_o && !irq_prev, cfg_ack, en_o};
        if (watch) begin
            for (int k = 0; k < NS; k++) begin
                if (ev[k]) begin
                    n_checks++;
                    if (exp_q[k].size() == 0) begin
                        n_err++;
                        $display("FAIL %s: event at cycle %0d, required none", sname[k], cyc - c0);
                    end else begin
                        e = exp_q[k].pop_front();
                        if (e != cyc) begin
                            n_err++;
                            $display("FAIL %s: event at cycle %0d, required cycle %0d",
                                     sname[k], cyc - c0, e - c0);
                        end
                    end
                end
            end
        end
        irq_prev <= irq_o;
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cfg_write(input int t, input logic [1:0] ch, input logic [CW-1:0] d);
        wait_cyc(t);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_div = d;
        wait_cyc(t + 1);
        cfg_we  = 1'b0;
    endtask

    task automatic push(input int k, input int ofs);
        exp_q[k].push_back(c0 + ofs);
    endtask

    initial begin
        rst     = 1'b1;
        run     = 1'b1;
        cfg_we  = 1'b0;
        cfg_ch  = '0;
        cfg_div = '0;

        wait_cyc(3);
        @(negedge clk);
        check("reset_en", 32'(en_o), 32'h0);
        check("reset_irq", 32'(irq_o), 32'h0);
        check("reset_ack", 32'(cfg_ack), 32'h0);

        wait_cyc(5);
        rst = 1'b0;
        c0  = cyc;

        // Expected events before the mid-run reset.
        foreach (EN0_OFS[i]) push(0, EN0_OFS[i]);
        foreach (EN1_OFS[i]) push(1, EN1_OFS[i]);
        for (int n = 0; n <= 16; n++) push(2, 9 + 10 * n);
        foreach (EN2_TAIL[i]) push(2, EN2_TAIL[i]);
        foreach (ACK_OFS[i]) push(3, ACK_OFS[i]);
        push(4, 130);
        push(5, 140);
        // Expected events after the mid-run reset: reset divisors, no ack.
        for (int o = C1 + 7; o <= END; o += 8) push(0, o);
        for (int o = C1 + 15; o <= END; o += 16) push(1, o);
        for (int o = C1 + 9; o <= END; o += 10) push(2, o);
        push(4, C1 + 130);
        push(5, C1 + 140);
        push(4, C1 + 270);
        push(5, C1 + 280);
        watch = 1'b1;

        for (int k = 0; k < 8; k++) begin
            wait_cyc(c0 + k);
            @(negedge clk);
            check($sformatf("level0_k%0d", k), 32'(level_o[0]), (k >= 4) ? 32'h1 : 32'h0);
        end

        cfg_write(c0 + 41, 2'd0, 16'd3);
        cfg_write(c0 + 81, 2'd0, 16'd15);
        cfg_write(c0 + 131, 2'd0, 16'd5);
        cfg_write(c0 + 171, 2'd2, 16'd9);
        cfg_write(c0 + 173, 2'd2, 16'd5);
        cfg_write(c0 + 181, 2'd3, 16'd2);

        wait_cyc(c0 + 198);
        run = 1'b0;
        wait_cyc(c0 + 220);
        @(negedge clk);
        check("frozen_en", 32'(en_o), 32'h0);
        check("frozen_level", 32'(level_o), 32'h2);
        wait_cyc(c0 + 248);
        run = 1'b1;

        cfg_write(c0 + 252, 2'd0, 16'd2);
        wait_cyc(c0 + 254);
        rst = 1'b1;
        wait_cyc(c0 + 255);
        @(negedge clk);
        check("midrst_en", 32'(en_o), 32'h0);
        check("midrst_irq", 32'(irq_o), 32'h0);
        check("midrst_ack", 32'(cfg_ack), 32'h0);
        wait_cyc(c0 + C1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_level", 32'(level_o), 32'h0);
        wait_cyc(c0 + C1 + 4);
        @(negedge clk);
        check("post_rst_level4", 32'(level_o), 32'h1);

        wait_cyc(c0 + END + 1);
        watch = 1'b0;
        for (int k = 0; k < NS; k++) begin
            n_checks++;
            if (exp_q[k].size() != 0) begin
                n_err++;
                $display("FAIL %s_missing: %0d events outstanding, required 0 (next at cycle %0d)",
                         sname[k], exp_q[k].size(), exp_q[k][0] - c0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
